// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_mem_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int NUMWORDS = 51200;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } state_e;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } rd_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the master not granted last wins a contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant != 2'b00) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/onchip_mem_rr_arbiter.sv
// Round-robin front end for the single-port on-chip RAM: two Avalon-MM masters,
// pipelined read return, and a freeze handshake that drains in-flight reads.
module onchip_mem_rr_arbiter #(
    parameter int ADDR_W       = onchip_mem_pkg::ADDR_W,
    parameter int DATA_W       = onchip_mem_pkg::DATA_W,
    parameter int NUMWORDS     = onchip_mem_pkg::NUMWORDS,
    parameter int READ_LATENCY = 1,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    input  logic              freeze,
    output logic              freeze_ack
);

    import onchip_mem_pkg::*;

    state_e      state, state_next;
    rd_entry_t   pipe [READ_LATENCY];
    rd_entry_t   ret;
    logic [1:0]  req, grant;
    logic        granted, sel, sel_write, sel_read, in_range, pipe_busy;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    ((state == RUN) && !freeze && !reset),
        .req   (req),
        .grant (grant)
    );

    assign granted        = |grant;
    assign sel            = grant[1];
    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];

    // Read and write together count as a write.
    assign sel_write      = sel ? m1_write : m0_write;
    assign sel_read       = granted & ~sel_write;

    assign mem_address    = sel ? m1_address    : m0_address;
    assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
    assign in_range       = 32'(mem_address) < NUMWORDS;
    assign mem_chipselect = granted & in_range;
    assign mem_write      = mem_chipselect & sel_write;
    assign mem_clken      = (state != FROZEN);

    always_ff @(posedge clk) begin
        // NOTE: the return pipeline is reset (unlike RAM contents) so in-flight reads are discarded.
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: sel_read, id: sel, oor: ~in_range};
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) pipe_busy = pipe_busy | pipe[i].valid;
    end

    // Gating with reset keeps a slot already at the output from escaping during reset.
    assign ret              = pipe[READ_LATENCY-1];
    assign m0_readdatavalid = ret.valid & ~ret.id & ~reset;
    assign m1_readdatavalid = ret.valid &  ret.id & ~reset;
    assign m0_readdata      = (m0_readdatavalid && !ret.oor) ? mem_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid && !ret.oor) ? mem_readdata : '0;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (freeze)     state_next = DRAIN;
            DRAIN:   if (!pipe_busy) state_next = FROZEN;
            FROZEN:  if (!freeze)    state_next = RUN;
            default:                 state_next = RUN;
        endcase
    end

    assign freeze_ack = (state == FROZEN);

endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// Randomized and directed bench for onchip_mem_rr_arbiter against a transaction-level model.
module tb_onchip_mem_rr_arbiter;

    localparam int NUMWORDS = 51200;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;
    logic        freeze, freeze_ack;

    always #5 clk = ~clk;

    onchip_mem_rr_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .freeze           (freeze),
        .freeze_ack       (freeze_ack)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // RAM with one cycle of read latency.
    logic [31:0] ram [NUMWORDS];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
            else           ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    // Transaction-level model state.
    logic [31:0] ref_mem [NUMWORDS];
    int          last_w;
    bit          pv [2];
    logic [31:0] pd [2];
    bit          acc [2];
    bit          exp_block, exp_ack;
    bit          obs_rdv [2], obs_wait [2], obs_cs;
    logic [31:0] obs_rd [2];
    int          n_tests, n_fail;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(int n, bit rd, bit wr, logic [15:0] a, logic [31:0] d, logic [3:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
    endtask

    // One bus cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit          r [2], wr [2];
        logic [15:0] ad [2];
        logic [31:0] wd [2];
        logic [3:0]  be [2];
        int          w;
        bit          inr;
        logic [31:0] rval;
        @(negedge clk);
        r[0] = m0_read | m0_write;  wr[0] = m0_write;  ad[0] = m0_address;  wd[0] = m0_writedata;  be[0] = m0_byteenable;
        r[1] = m1_read | m1_write;  wr[1] = m1_write;  ad[1] = m1_address;  wd[1] = m1_writedata;  be[1] = m1_byteenable;
        w = -1;
        if (!exp_block) begin
            if (r[0] && r[1]) w = 1 - last_w;
            else if (r[0])    w = 0;
            else if (r[1])    w = 1;
        end
        obs_rdv[0] = m0_readdatavalid;  obs_rd[0] = m0_readdata;  obs_wait[0] = m0_waitrequest;
        obs_rdv[1] = m1_readdatavalid;  obs_rd[1] = m1_readdata;  obs_wait[1] = m1_waitrequest;
        obs_cs     = mem_chipselect;
        check("m0_waitrequest", m0_waitrequest, w != 0);
        check("m1_waitrequest", m1_waitrequest, w != 1);
        check("m0_readdatavalid", m0_readdatavalid, pv[0]);
        check("m1_readdatavalid", m1_readdatavalid, pv[1]);
        check("m0_readdata", m0_readdata, pv[0] ? pd[0] : 32'h0);
        check("m1_readdata", m1_readdata, pv[1] ? pd[1] : 32'h0);
        check("freeze_ack", freeze_ack, exp_ack);
        check("mem_clken", mem_clken, !exp_ack);
        if (w >= 0) begin
            inr = int'(ad[w]) < NUMWORDS;
            check("mem_chipselect", mem_chipselect, inr);
            check("mem_write", mem_write, inr && wr[w]);
            if (inr) check("mem_address", mem_address, ad[w]);
            if (inr && wr[w]) begin
                check("mem_writedata", mem_writedata, wd[w]);
                check("mem_byteenable", mem_byteenable, be[w]);
            end
            rval = inr ? ref_mem[ad[w]] : 32'h0;
            for (int n = 0; n < 2; n++) begin
                pv[n]  = (w == n) && !wr[w];
                pd[n]  = rval;
                acc[n] = (w == n);
            end
            if (inr && wr[w]) ref_mem[ad[w]] = merge(ref_mem[ad[w]], wd[w], be[w]);
            last_w = w;
        end else begin
            check("mem_chipselect_idle", mem_chipselect, 0);
            check("mem_write_idle", mem_write, 0);
            for (int n = 0; n < 2; n++) begin
                pv[n]  = 1'b0;
                acc[n] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int cycles);
        reset  = 1'b1;
        freeze = 1'b0;
        idle();
        @(posedge clk);
        #1;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_m0_readdatavalid", m0_readdatavalid, 0);
            check("rst_m1_readdatavalid", m1_readdatavalid, 0);
            check("rst_m0_readdata", m0_readdata, 0);
            check("rst_m1_readdata", m1_readdata, 0);
            check("rst_freeze_ack", freeze_ack, 0);
            check("rst_mem_chipselect", mem_chipselect, 0);
            check("rst_mem_write", mem_write, 0);
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        last_w    = 1;
        pv[0]     = 1'b0;
        pv[1]     = 1'b0;
        acc[0]    = 1'b0;
        acc[1]    = 1'b0;
        exp_block = 1'b0;
        exp_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rr [2], rw [2];
        logic [15:0] ra [2];
        logic [31:0] rdat [2];
        logic [3:0]  rb [2];
        int          k0, k1, op;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        freeze  = 1'b0;
        idle();
        do_reset(3);

        // Preload through the arbiter.
        drive(0, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF); tick();
        drive(0, 0, 1, 16'h0020, 32'hAAAAAAAA, 4'hF); tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 16'h0040 + 16'(i), $urandom, 4'hF);
            tick();
        end
        idle(); tick();

        // Read straight out of reset.
        do_reset(2);
        drive(0, 1, 0, 16'h0010, '0, '0); tick();
        check("t1_m0_accept", obs_wait[0], 0);
        idle(); tick();
        check("t1_m0_rdv", obs_rdv[0], 1);
        check("t1_m0_rdata", obs_rd[0], 32'hDEADBEEF);
        check("t1_m1_rdv", obs_rdv[1], 0);

        // Both masters write continuously: strict alternation starting with m0.
        do_reset(1);
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 1, 16'h0044 + 16'(k0), 32'hC0DE0000 + 32'(k0), 4'hF);
            drive(1, 0, 1, 16'h0048 + 16'(k1), 32'hBEEF0100 + 32'(k1), 4'hF);
            tick();
            check($sformatf("t2_grant_%0d", c), obs_wait[0] ? 1 : 0, c % 2);
            if (!obs_wait[0]) k0++;
            if (!obs_wait[1]) k1++;
        end
        check("t2_m0_writes", k0, 3);
        check("t2_m1_writes", k1, 3);
        idle(); tick();

        // Partial write then read back.
        drive(1, 0, 1, 16'h0020, 32'h11223344, 4'b0101); tick();
        drive(1, 1, 0, 16'h0020, '0, '0); tick();
        idle(); tick();
        check("t3_be_rdata", obs_rd[1], 32'hAA22AA44);

        // Out-of-range read and write.
        drive(0, 1, 0, 16'd51200, '0, '0); tick();
        check("t4_rd_cs", obs_cs, 0);
        drive(0, 0, 1, 16'hFFFF, 32'h12345678, 4'hF); tick();
        check("t4_wr_cs", obs_cs, 0);
        check("t4_oor_rdv", obs_rdv[0], 1);
        check("t4_oor_rdata", obs_rd[0], 0);
        idle(); tick();

        // Freeze with reads in flight on both masters.
        drive(0, 1, 0, 16'h0010, '0, '0);
        drive(1, 1, 0, 16'h0020, '0, '0);
        tick(); tick();
        freeze = 1'b1; exp_block = 1'b1; tick();
        check("t5_drain_rdv", obs_rdv[0] | obs_rdv[1], 1);
        tick();
        exp_ack = 1'b1; tick(); tick();
        freeze = 1'b0; tick();
        exp_block = 1'b0; exp_ack = 1'b0; tick();
        check("t5_resume", obs_wait[0] & obs_wait[1], 0);
        idle(); tick(); tick();

        // Reset one cycle after a read issue.
        drive(0, 1, 0, 16'h0010, '0, '0); tick();
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("t6_m0_rdv", m0_readdatavalid, 0);
        check("t6_m1_rdv", m1_readdatavalid, 0);
        do_reset(2);
        tick(); tick();

        // Randomized traffic; masters hold a command until it is accepted.
        for (int n = 0; n < 2; n++) begin
            rr[n] = 1'b0;
            rw[n] = 1'b0;
        end
        for (int c = 0; c < 300; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(rr[n] | rw[n]) || acc[n]) begin
                    op      = $urandom_range(0, 3);
                    rr[n]   = op[0];
                    rw[n]   = op[1];
                    ra[n]   = ($urandom_range(0, 9) == 0) ? 16'(51200 + $urandom_range(0, 14335))
                                                         : 16'(16'h0040 + $urandom_range(0, 15));
                    rdat[n] = $urandom;
                    rb[n]   = 4'($urandom_range(0, 15));
                end
                drive(n, rr[n], rw[n], ra[n], rdat[n], rb[n]);
            end
            tick();
        end
        idle(); tick(); tick();

        for (int a = 16'h0040; a < 16'h0050; a++) check($sformatf("ram_%04h", a), ram[a], ref_mem[a]);
        check("ram_0010", ram[16'h0010], ref_mem[16'h0010]);
        check("ram_0020", ram[16'h0020], ref_mem[16'h0020]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
